// File: rtl/keypad_entry_if.sv
// Key-event bundle from the keypad scanner: accepted key pulses plus the
// assembled decimal value and the last value latched by Enter.
interface keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] working_number;
    logic [2:0]  digit_count;
    logic [15:0] entered_number;
    logic        entered_valid;

    modport master (
        output key_valid, key_code, working_number,
               digit_count, entered_number, entered_valid
    );

    modport slave (
        input key_valid, key_code, working_number,
              digit_count, entered_number, entered_valid
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and 4-digit decimal entry.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of held digit keys.
module keypad_entry #(
    parameter int SCAN_CYCLES        = 100000,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 125,
    parameter int REPEAT_RATE_SCANS  = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    row_n,
    output logic [3:0]    col_n,
    keypad_entry_if.master kp
);

    localparam int SW      = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_DELAY_SCANS)
                           ? ((DEBOUNCE_SCANS > REPEAT_RATE_SCANS) ? DEBOUNCE_SCANS : REPEAT_RATE_SCANS)
                           : ((REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ? REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS);
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    logic [3:0]      row_meta_reg, row_sync_reg;
    logic [SW-1:0]   slot_reg;
    logic [1:0]      col_reg;
    logic [3:0]      col_n_reg;
    logic [4:0]      hit_cnt_reg;
    logic [3:0]      hit_code_reg;
    state_t          state_reg;
    logic [3:0]      cand_reg;
    logic [CW-1:0]   cnt_reg;
`ifdef KEYPAD_REPEAT_EN
    logic            rep_phase_reg;
`endif
    logic            key_valid_reg;
    logic [3:0]      key_code_reg;
    logic [3:0][3:0] digits_reg;
    logic [2:0]      count_reg;
    logic [15:0]     entered_reg;
    logic            entered_valid_reg;

    function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    logic [3:0] row_hit;
    logic [3:0] row_code [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_hit[gi]  = ~row_sync_reg[gi];
            assign row_code[gi] = key_at(2'(gi), col_reg);
        end
    endgenerate

    logic          slot_last, sweep_end, sweep_none, sweep_single;
    logic [4:0]    sweep_cnt;
    logic [3:0]    sweep_code;
    logic [CW-1:0] cnt_inc;
    logic          accept;

    // Closed switches accumulate across the four column slots of a sweep;
    // the column-0 sample starts a fresh tally.
    always_comb begin
        slot_last  = (slot_reg == SW'(SCAN_CYCLES - 1));
        sweep_end  = slot_last && (col_reg == 2'd3);
        sweep_cnt  = (col_reg == 2'd0) ? 5'd0 : hit_cnt_reg;
        sweep_code = (col_reg == 2'd0) ? 4'd0 : hit_code_reg;
        for (int r = 0; r < 4; r++) begin
            if (row_hit[r]) begin
                sweep_cnt  = sweep_cnt + 5'd1;
                sweep_code = row_code[r];
            end
        end
        sweep_none   = (sweep_cnt == 5'd0);
        sweep_single = (sweep_cnt == 5'd1);
        cnt_inc      = cnt_reg + CW'(1);
    end

    always_comb begin
        accept = 1'b0;
        if (sweep_end && sweep_single) begin
            case (state_reg)
                IDLE:     accept = (DEBOUNCE_SCANS == 1);
                PRESS_DB: accept = (sweep_code == cand_reg) && (cnt_inc == CW'(DEBOUNCE_SCANS));
`ifdef KEYPAD_REPEAT_EN
                HELD:     accept = (sweep_code == cand_reg) && (cand_reg <= 4'd9) &&
                                   (rep_phase_reg ? (cnt_inc == CW'(REPEAT_RATE_SCANS))
                                                  : (cnt_inc == CW'(REPEAT_DELAY_SCANS)));
`endif
                default:  accept = 1'b0;
            endcase
        end
    end

    logic [15:0] working;
    assign working = 16'(digits_reg[3]) * 16'd1000 + 16'(digits_reg[2]) * 16'd100
                   + 16'(digits_reg[1]) * 16'd10   + 16'(digits_reg[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_reg      <= 4'hF;
            row_sync_reg      <= 4'hF;
            slot_reg          <= '0;
            col_reg           <= 2'd0;
            col_n_reg         <= 4'b1110;
            hit_cnt_reg       <= 5'd0;
            hit_code_reg      <= 4'd0;
            state_reg         <= IDLE;
            cand_reg          <= 4'd0;
            cnt_reg           <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_phase_reg     <= 1'b0;
`endif
            key_valid_reg     <= 1'b0;
            key_code_reg      <= 4'd0;
            digits_reg        <= '0;
            count_reg         <= 3'd0;
            entered_reg       <= 16'd0;
            entered_valid_reg <= 1'b0;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;

            if (slot_last) begin
                slot_reg     <= '0;
                col_reg      <= col_reg + 2'd1;
                col_n_reg    <= {col_n_reg[2:0], col_n_reg[3]};
                hit_cnt_reg  <= sweep_cnt;
                hit_code_reg <= sweep_code;
            end else begin
                slot_reg <= slot_reg + SW'(1);
            end

            if (sweep_end) begin
                case (state_reg)
                    IDLE: begin
                        if (sweep_single) begin
                            cand_reg <= sweep_code;
                            if (accept) begin
                                state_reg <= HELD;
                                cnt_reg   <= '0;
                            end else begin
                                state_reg <= PRESS_DB;
                                cnt_reg   <= CW'(1);
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (sweep_single && sweep_code == cand_reg) begin
                            if (accept) begin
                                state_reg <= HELD;
                                cnt_reg   <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rep_phase_reg <= 1'b0;
`endif
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    HELD: begin
                        if (sweep_none) begin
                            cnt_reg   <= CW'(1);
                            state_reg <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_DB;
                        end else if (sweep_single && sweep_code == cand_reg) begin
`ifdef KEYPAD_REPEAT_EN
                            if (accept) begin
                                cnt_reg       <= '0;
                                rep_phase_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
`endif
                        end else begin
                            cnt_reg <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_phase_reg <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        if (sweep_none) begin
                            if (cnt_inc == CW'(DEBOUNCE_SCANS)) state_reg <= IDLE;
                            else                                 cnt_reg   <= cnt_inc;
                        end else begin
                            state_reg <= HELD;
                            cnt_reg   <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_phase_reg <= 1'b0;
`endif
                        end
                    end
                endcase
            end

            key_valid_reg     <= accept;
            entered_valid_reg <= 1'b0;
            if (accept) begin
                key_code_reg <= sweep_code;
                if (sweep_code <= 4'd9) begin
                    digits_reg <= {digits_reg[2:0], sweep_code};
                    count_reg  <= count_reg + ((count_reg != 3'd4) ? 3'd1 : 3'd0);
                end else if (sweep_code == 4'hC) begin
                    digits_reg <= '0;
                    count_reg  <= 3'd0;
                end else if (sweep_code == 4'hE) begin
                    entered_reg       <= working;
                    entered_valid_reg <= 1'b1;
                    digits_reg        <= '0;
                    count_reg         <= 3'd0;
                end
            end
        end
    end

    assign col_n             = col_n_reg;
    assign kp.key_valid      = key_valid_reg;
    assign kp.key_code       = key_code_reg;
    assign kp.working_number = working;
    assign kp.digit_count    = count_reg;
    assign kp.entered_number = entered_reg;
    assign kp.entered_valid  = entered_valid_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: sweep-aligned keypad stimulus, event-level reference
// model feeding a scoreboard queue, and a per-cycle monitor.
module tb_keypad_entry;
    localparam int SC    = 4;
    localparam int DEB   = 2;
    localparam int RD    = 3;
    localparam int RR    = 2;
    localparam int SWEEP = 4 * SC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] pressed = 16'h0;

    keypad_entry_if kp_bus ();

    keypad_entry #(
        .SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DEB),
        .REPEAT_DELAY_SCANS(RD), .REPEAT_RATE_SCANS(RR)
    ) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .kp(kp_bus)
    );

    always #5 clk = ~clk;

    // Matrix model: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
    end

    typedef struct {int cyc; int code; int wn; int dc; int en; bit ev;} exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int keymap [16];
    int m_val, m_cnt, m_ent, sweep_no;
    bit m_idle;
    int c_code, c_wn, c_dc, c_en;

    always_ff @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] kmask(input int code);
        logic [15:0] m = 16'h0;
        for (int i = 0; i < 16; i++) if (keymap[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_accept(input int code, input int s);
        exp_t e;
        e.ev = 1'b0;
        if (code <= 9) begin
            m_val = (m_val * 10 + code) % 10000;
            if (m_cnt < 4) m_cnt++;
        end else if (code == 12) begin
            m_val = 0; m_cnt = 0;
        end else if (code == 14) begin
            m_ent = m_val; m_val = 0; m_cnt = 0; e.ev = 1'b1;
        end
        e.cyc = SWEEP * (s + 1);
        e.code = code; e.wn = m_val; e.dc = m_cnt; e.en = m_ent;
        q.push_back(e);
        $display("expect key=%0h at cyc=%0d wn=%0d dc=%0d en=%0d", code, e.cyc, m_val, m_cnt, m_ent);
    endtask

    // Hold a key mask for n whole sweeps; predict events at the debounce point
    // (and repeat points when enabled) from the segment's length alone.
    task automatic seg(input logic [15:0] mask, input int n);
        int idx, code;
        if ($countones(mask) == 1 && n >= DEB && m_idle) begin
            idx = 0;
            for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
            code = keymap[idx];
            model_accept(code, sweep_no + DEB - 1);
`ifdef KEYPAD_REPEAT_EN
            if (code <= 9)
                for (int o = DEB - 1 + RD; o < n; o += RR) model_accept(code, sweep_no + o);
`endif
            m_idle = 1'b0;
        end else if (mask == 16'h0 && n >= DEB) begin
            m_idle = 1'b1;
        end
        pressed = mask;
        repeat (n * SWEEP) @(negedge clk);
        sweep_no += n;
    endtask

    task automatic model_reset();
        m_val = 0; m_cnt = 0; m_ent = 0; m_idle = 1'b1; sweep_no = 0;
    endtask

    // Monitor: col_n sequence, reset values, and scoreboard pops on key_valid.
    initial begin
        logic [3:0] col_exp;
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            col_exp = ~(4'b0001 << ((cyc / SC) % 4));
            check("col_n", int'(col_n), int'(col_exp));
            if (reset) begin
                c_code = 0; c_wn = 0; c_dc = 0; c_en = 0;
                check("reset_key_valid", int'(kp_bus.key_valid), 0);
                check("reset_entered_valid", int'(kp_bus.entered_valid), 0);
            end else if (kp_bus.key_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_key_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("event_cyc", cyc, e.cyc);
                    check("entered_valid_evt", int'(kp_bus.entered_valid), int'(e.ev));
                    c_code = e.code; c_wn = e.wn; c_dc = e.dc; c_en = e.en;
                    $display("event key=%0h cyc=%0d wn=%0d dc=%0d en=%0d",
                             kp_bus.key_code, cyc, kp_bus.working_number,
                             kp_bus.digit_count, kp_bus.entered_number);
                end
            end else begin
                check("entered_valid_idle", int'(kp_bus.entered_valid), 0);
            end
            check("key_code", int'(kp_bus.key_code), c_code);
            check("working_number", int'(kp_bus.working_number), c_wn);
            check("digit_count", int'(kp_bus.digit_count), c_dc);
            check("entered_number", int'(kp_bus.entered_number), c_en);
        end
    end

    initial begin
        int kind, code, n, b1, b2;
        keymap = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        seg(16'h0, 20);
        seg(kmask(5), 12);
        seg(16'h0, 4);
        for (int d = 1; d <= 5; d++) begin
            seg(kmask(d), 3);
            seg(16'h0, 2);
        end
        check("wn_2345", int'(kp_bus.working_number), 2345);
        check("dc_4", int'(kp_bus.digit_count), 4);
        seg(kmask(12), 3); seg(16'h0, 2);
        check("wn_clear", int'(kp_bus.working_number), 0);
        seg(kmask(7), 3);  seg(16'h0, 2);
        seg(kmask(14), 3); seg(16'h0, 2);
        check("entered_7", int'(kp_bus.entered_number), 7);

        for (int i = 0; i < 5; i++) begin
            seg(kmask(8), 1);
            seg(16'h0, 1);
        end
        seg(16'h0, 2);
        seg(kmask(1) | kmask(2), 6);
        seg(16'h0, 2);

        // Reset while '3' is part-way through press debounce.
        check("queue_empty_before_reset", q.size(), 0);
        pressed = kmask(3);
        repeat (SWEEP + 5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        seg(kmask(3), 4);
        seg(16'h0, 3);

        seg(kmask(9), DEB + 10);
        seg(16'h0, 3);
`ifdef KEYPAD_REPEAT_EN
        check("wn_9999", int'(kp_bus.working_number), 9999);
`endif
        seg(kmask(12), DEB + 10);
        seg(16'h0, 3);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                code = $urandom_range(0, 15);
                seg(kmask(code), $urandom_range(DEB, DEB + 6));
                seg(16'h0, $urandom_range(DEB, DEB + 2));
            end else if (kind <= 7) begin
                code = $urandom_range(0, 15);
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    seg(kmask(code), 1);
                    seg(16'h0, 1);
                end
                seg(16'h0, DEB);
            end else begin
                b1 = $urandom_range(0, 15);
                b2 = (b1 + $urandom_range(1, 15)) % 16;
                seg((16'h1 << b1) | (16'h1 << b2), $urandom_range(1, 4));
                seg(16'h0, DEB);
            end
        end

        seg(16'h0, 3);
        check("pending_events", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Scans a 4x4 active-low matrix keypad (Pmod KYPD layout), debounces it, and decodes each press into a hex key code.
- Assembles up to 4 decimal digits into a binary value, 0..9999.
- Input-side counterpart of the 7-segment display driver: working_number or entered_number feeds the display's 16-bit displayed_number directly.

Parameters:
- SCAN_CYCLES, 100000, clocks per column slot (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full sweeps required to accept a press or release; minimum 1.
- REPEAT_DELAY_SCANS, 125, sweeps held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE_SCANS, 25, sweeps between subsequent repeats (used only with KEYPAD_REPEAT_EN).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- row_n  in  4  keypad rows, active low, asynchronous; row_n[r] = row r.
- col_n  out  4  column drive, active-low one-hot; col_n[c]=0 drives column c.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_code  out  4  code of the last accepted key; holds between events.
- working_number  out  16  binary value of digits entered so far.
- digit_count  out  3  digits held, 0..4.
- entered_number  out  16  value latched by Enter.
- entered_valid  out  1  one-cycle pulse when entered_number updates.

Behaviour:
- Reset values: col_n=4'b1110, key_valid=0, key_code=0, working_number=0, digit_count=0, entered_number=0, entered_valid=0. All counters are 0 and the FSM is in IDLE.
- row_n passes through a 2-flop synchronizer before any use.
- Column slot counter:
  - Counts 0..SCAN_CYCLES-1; column index advances 0→1→2→3→0 on wrap.
  - Synchronized rows are sampled on the last cycle of each slot.
  - A sweep completes at the col-3 sample; the sweep result is then NONE, SINGLE(code) or MULTI (more than one switch closed).
- Key map, (row,col) → code:
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: 0, F, E, D.
- FSM, evaluated once per sweep end:
  - IDLE: SINGLE(k) → cand=k, cnt=1, go PRESS_DB. If DEBOUNCE_SCANS=1, accept immediately.
  - PRESS_DB: SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go HELD. Any other result → IDLE, no event.
  - HELD: NONE → cnt=1, go RELEASE_DB. Any other result → stay.
  - RELEASE_DB: NONE → cnt+1; at DEBOUNCE_SCANS → IDLE. Any key → HELD, no new event.
  - MULTI (ghosting) never generates an event.
- Accept:
  - key_valid=1 for exactly one cycle, in the cycle after the deciding sweep end.
  - key_code, digit registers, digit_count, entered_number and entered_valid all update on the same edge as key_valid.
- Key processing:
  - Digits 0-9: four BCD digit registers shift left, new digit into d0; digit_count increments, saturating at 4. With 4 digits held, the MSD is dropped: 2345 + '6' → 3456.
  - C: all digits 0, digit_count=0.
  - E: entered_number ← working value before the press; entered_valid pulses; digits and count clear.
  - A, B, D, F: key_valid/key_code only.
- working_number = d3*1000 + d2*100 + d1*10 + d0, combinational from the digit registers. It is valid in the key_valid cycle and never exceeds 9999.
- Reset mid-operation:
  - Immediate return to reset values; no pending event is emitted.
  - A key still held after reset is debounced afresh from IDLE and produces one event.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined, digit keys auto-repeat:
  - In HELD with the same SINGLE, an extra accept occurs after REPEAT_DELAY_SCANS sweeps.
  - Further accepts follow every REPEAT_RATE_SCANS sweeps until the key is released.
  - C, E, A, B, D, F never repeat.
- Undefined: exactly one event per debounced press; REPEAT_* parameters are ignored.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=2, REPEAT_DELAY_SCANS=3, REPEAT_RATE_SCANS=2):
- Reset, no keys → all outputs at reset values; col_n cycles 1110,1101,1011,0111, 4 clocks each; no key_valid over 20 sweeps.
- Hold '5' (row_n[1]=0 while col 1 driven) for 12 sweeps → single key_valid with key_code=5, working_number=5, digit_count=1. Release → no further pulses.
- Press/release 1,2,3,4,5 → working_number=2345, digit_count=4. Then C → working_number=0, digit_count=0.
- Press 7 then E → entered_number=7, entered_valid high exactly one cycle coincident with key_valid (key_code=E), working_number=0.
- Bounce and ghosting:
  - '8' present 1 sweep, absent 1 sweep, repeated 5× → no key_valid.
  - '1'+'2' held together → no key_valid.
  - Reset asserted mid-PRESS_DB for '3', '3' still held after → one event after 2 sweeps.
- With KEYPAD_REPEAT_EN, hold '9' 10 sweeps after accept → events at accept, +3, +5, +7, +9 sweeps; working_number=9999 (4 digits held, then MSD dropped on the 5th). Hold 'C' → one event only.
